ifetch_queue: RTL

Instruction fetch stage directly downstream of the instruction cache. Owns the PC, drives the icache request side of the datapath/cache interface, and buffers returned instructions with their PCs in a small FIFO. The decode stage consumes the FIFO through a valid/ready handshake. Branch and jump resolution redirects the fetch stream with a single-cycle flush.

---
 rtl/ifetch_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, issues icache requests and buffers {pc, instr} in a small FIFO for decode.
// Optional performance counters are built when FETCH_PERF_EN is defined; otherwise both counter ports are tied to zero.
module ifetch_queue #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_npc,
    input  logic        out_ready,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [1:0]  fetch_state
);
    // Handshake: decode takes the head on any cycle where out_valid && out_ready;
    // out_valid never depends on out_ready.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_BLOCKED = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];
    logic [31:0]   ins_mem_d [DEPTH];

    logic full, empty, push, pop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign imemREN   = !RST && !full && !halt && !redirect;
    assign imemaddr  = pc_q;
    assign push      = imemREN && ihit;
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;
    assign out_instr = ins_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];
    assign out_npc   = pc_mem_q[head_q] + 32'd4;

    // Fetch state is a pure decode of the current inputs; nothing is stored.
    always_comb begin
        fetch_state = ST_BLOCKED;
        if (redirect)
            fetch_state = ST_FLUSH;
        else if (imemREN)
            fetch_state = ST_FETCH;
    end

    always_comb begin
        pc_d      = pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pc_mem_d  = pc_mem_q;
        ins_mem_d = ins_mem_q;
        if (redirect) begin
            // Flush wins over any concurrent hit or pop.
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[tail_q]  = pc_q;
                ins_mem_d[tail_q] = imemload;
                tail_d            = tail_q + 1'b1;
                pc_d              = pc_q + 32'd4;
            end
            if (pop)
                head_d = head_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= PC_RESET;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pc_mem_q  <= pc_mem_d;
            ins_mem_q <= ins_mem_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (imemREN && !ihit && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif
endmodule
